// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: 32-iteration shift-add multiplier and restoring divider with sign fix-up.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier is zero.
module hilo_muldiv_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] rs_content,
   input  logic [31:0] rt_content,
   output logic        op_ready,
   output logic        busy,
   output logic        done,
   input  logic        rd_req,
   input  logic        rd_sel,
   output logic [31:0] rd_data,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIX = 2'd2} state_t;

   state_t      state_r;
   logic [31:0] hi_r, lo_r;
   logic        done_r, busy_r, op_ready_r;
   logic [4:0]  cnt_r;
   logic        is_div_r, neg_res_r, neg_rem_r, dz_r;
   logic [31:0] rs_raw_r;
   logic [63:0] prod_r, mcand_r;
   logic [31:0] mplier_r;
   logic [31:0] rem_r, quo_r, dvsr_r;

   logic        is_signed_s, last_iter_s, ge_s;
   logic [31:0] a_s, b_s, sub_s, quo_fix_s, rem_fix_s;
   logic [32:0] shl_s;
   logic [63:0] prod_add_s, prod_fix_s;

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

   // Operand magnitudes, one iteration step of each datapath, and final sign correction.
   always_comb begin
      is_signed_s = (op_code[0] == 1'b0);
      a_s         = is_signed_s ? abs32(rs_content) : rs_content;
      b_s         = is_signed_s ? abs32(rt_content) : rt_content;
      // Multiplicand shifts left instead of the accumulator shifting right, so an early
      // exit leaves the product already aligned.
      prod_add_s  = mplier_r[0] ? (prod_r + mcand_r) : prod_r;
      shl_s       = {rem_r, quo_r[31]};
      ge_s        = (shl_s >= {1'b0, dvsr_r});
      sub_s       = shl_s[31:0] - dvsr_r;
`ifdef MULDIV_EARLY_OUT_EN
      last_iter_s = (cnt_r == 5'd0) || (!is_div_r && (mplier_r[31:1] == 31'd0));
`else
      last_iter_s = (cnt_r == 5'd0);
`endif
      prod_fix_s  = neg_res_r ? (64'd0 - prod_r) : prod_r;
      quo_fix_s   = neg_res_r ? (32'd0 - quo_r) : quo_r;
      rem_fix_s   = neg_rem_r ? (32'd0 - rem_r) : rem_r;
   end

   // Sequencer FSM, iteration datapath registers and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         hi_r       <= 32'd0;
         lo_r       <= 32'd0;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
         op_ready_r <= 1'b1;
         cnt_r      <= 5'd0;
         is_div_r   <= 1'b0;
         neg_res_r  <= 1'b0;
         neg_rem_r  <= 1'b0;
         dz_r       <= 1'b0;
         rs_raw_r   <= 32'd0;
         prod_r     <= 64'd0;
         mcand_r    <= 64'd0;
         mplier_r   <= 32'd0;
         rem_r      <= 32'd0;
         quo_r      <= 32'd0;
         dvsr_r     <= 32'd0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (op_valid) begin
                  case (op_code)
                     3'b100: hi_r <= rs_content;
                     3'b101: lo_r <= rs_content;
                     3'b000, 3'b001, 3'b010, 3'b011: begin
                        is_div_r   <= op_code[1];
                        neg_res_r  <= is_signed_s & (rs_content[31] ^ rt_content[31]);
                        neg_rem_r  <= is_signed_s & rs_content[31];
                        dz_r       <= op_code[1] & (rt_content == 32'd0);
                        rs_raw_r   <= rs_content;
                        prod_r     <= 64'd0;
                        mcand_r    <= {32'd0, a_s};
                        mplier_r   <= b_s;
                        rem_r      <= 32'd0;
                        quo_r      <= a_s;
                        dvsr_r     <= b_s;
                        cnt_r      <= 5'd31;
                        state_r    <= ST_RUN;
                        busy_r     <= 1'b1;
                        op_ready_r <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               if (is_div_r) begin
                  rem_r <= ge_s ? sub_s : shl_s[31:0];
                  quo_r <= {quo_r[30:0], ge_s};
               end else begin
                  prod_r   <= prod_add_s;
                  mcand_r  <= {mcand_r[62:0], 1'b0};
                  mplier_r <= {1'b0, mplier_r[31:1]};
               end
               cnt_r <= last_iter_s ? 5'd0 : (cnt_r - 5'd1);
               if (last_iter_s) begin
                  state_r <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (dz_r) begin
                  lo_r <= 32'hFFFF_FFFF;
                  hi_r <= rs_raw_r;
               end else if (is_div_r) begin
                  lo_r <= quo_fix_s;
                  hi_r <= rem_fix_s;
               end else begin
                  lo_r <= prod_fix_s[31:0];
                  hi_r <= prod_fix_s[63:32];
               end
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               op_ready_r <= 1'b1;
               done_r     <= 1'b1;
            end
            default: begin
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               op_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign op_ready = op_ready_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign hi       = hi_r;
   assign lo       = lo_r;
   assign rd_data  = rd_sel ? hi_r : lo_r;
   assign stall    = busy_r & (rd_req | op_valid);
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl; expected busy lengths follow MULDIV_EARLY_OUT_EN.
module tb_hilo_muldiv_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic [2:0]  op_code = 3'b000;
   logic [31:0] rs_content = 32'd0;
   logic [31:0] rt_content = 32'd0;
   logic        rd_req = 1'b0;
   logic        rd_sel = 1'b0;
   logic        op_ready, busy, done, stall;
   logic [31:0] rd_data, hi, lo;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   hilo_muldiv_ctrl dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .rs_content(rs_content), .rt_content(rt_content), .op_ready(op_ready),
      .busy(busy), .done(done), .rd_req(rd_req), .rd_sel(rd_sel),
      .rd_data(rd_data), .stall(stall), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Presents one mul/div op at a negedge, then counts busy cycles until done (bounded).
   task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         output int busy_n, output int done_at, output logic rdy_at_done);
      op_valid = 1'b1; op_code = code; rs_content = a; rt_content = b;
      @(posedge clk); #1;
      op_valid = 1'b0;
      busy_n = 0; done_at = 0; rdy_at_done = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (done) begin
            done_at = k; rdy_at_done = op_ready;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want %h", hi, 32'd0); end
      n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want %h", lo, 32'd0); end
      n_cmp++; if ({op_ready, busy, done, stall} !== 4'b1000) begin n_bad++;
         $display("FAIL reset_flags: got %b want %b", {op_ready, busy, done, stall}, 4'b1000); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_multu_max;
      int bn, da; logic rdy;
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bn, da, rdy);
      n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_max_hi: got %h want %h", hi, 32'hFFFF_FFFE); end
      n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_max_lo: got %h want %h", lo, 32'h0000_0001); end
      n_cmp++; if (bn !== 33) begin n_bad++; $display("FAIL multu_max_busy: got %0d want %0d", bn, 33); end
      n_cmp++; if (da !== 34) begin n_bad++; $display("FAIL multu_max_done_cycle: got %0d want %0d", da, 34); end
      n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL multu_max_ready_at_done: got %b want %b", rdy, 1'b1); end
   endtask

   task automatic test_mult_signed;
      int bn, da; logic rdy;
      int exp_busy;
      exp_busy = EARLY ? 4 : 33;
      run_op(3'b000, 32'hFFFF_FFFD, 32'd5, bn, da, rdy);
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi: got %h want %h", hi, 32'hFFFF_FFFF); end
      n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mult_neg_lo: got %h want %h", lo, 32'hFFFF_FFF1); end
      n_cmp++; if (da !== exp_busy + 1) begin n_bad++; $display("FAIL mult_neg_done_cycle: got %0d want %0d", da, exp_busy + 1); end
   endtask

   task automatic test_back_to_back_div;
      int bn, da; logic rdy;
      run_op(3'b010, 32'hFFFF_FFF9, 32'd2, bn, da, rdy);
      n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg_lo: got %h want %h", lo, 32'hFFFF_FFFD); end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_neg_hi: got %h want %h", hi, 32'hFFFF_FFFF); end
      n_cmp++; if (bn !== 33) begin n_bad++; $display("FAIL div_neg_busy: got %0d want %0d", bn, 33); end
      // issued in the done cycle of the previous divide
      run_op(3'b011, 32'd7, 32'd2, bn, da, rdy);
      n_cmp++; if (lo !== 32'd3) begin n_bad++; $display("FAIL divu_lo: got %h want %h", lo, 32'd3); end
      n_cmp++; if (hi !== 32'd1) begin n_bad++; $display("FAIL divu_hi: got %h want %h", hi, 32'd1); end
      n_cmp++; if (da !== 34) begin n_bad++; $display("FAIL divu_b2b_done_cycle: got %0d want %0d", da, 34); end
   endtask

   task automatic test_div_edges;
      int bn, da; logic rdy;
      run_op(3'b011, 32'd5, 32'd0, bn, da, rdy);
      n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divu_zero_lo: got %h want %h", lo, 32'hFFFF_FFFF); end
      n_cmp++; if (hi !== 32'd5) begin n_bad++; $display("FAIL divu_zero_hi: got %h want %h", hi, 32'd5); end
      n_cmp++; if (bn !== 33) begin n_bad++; $display("FAIL divu_zero_busy: got %0d want %0d", bn, 33); end
      run_op(3'b010, 32'hFFFF_FFF9, 32'd0, bn, da, rdy);
      n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_zero_lo: got %h want %h", lo, 32'hFFFF_FFFF); end
      n_cmp++; if (hi !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL div_zero_hi_raw: got %h want %h", hi, 32'hFFFF_FFF9); end
      run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, bn, da, rdy);
      n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL div_ovf_lo: got %h want %h", lo, 32'h8000_0000); end
      n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL div_ovf_hi: got %h want %h", hi, 32'd0); end
   endtask

   task automatic test_stall_read;
      int stall_n, da, exp_busy;
      logic st_d; logic [31:0] rd_d;
      exp_busy = EARLY ? 3 : 33;
      stall_n = 0; da = 0; st_d = 1'b1; rd_d = 32'hXXXX_XXXX;
      op_valid = 1'b1; op_code = 3'b001; rs_content = 32'd2; rt_content = 32'd3;
      @(posedge clk); #1;
      op_valid = 1'b0; rd_req = 1'b1; rd_sel = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (done) begin
            da = k; st_d = stall; rd_d = rd_data;
            break;
         end
         if (stall) stall_n++;
         if (k == 1) begin
            op_valid = 1'b1; op_code = 3'b101; rs_content = 32'hDEAD_BEEF;
         end else begin
            op_valid = 1'b0;
         end
      end
      op_valid = 1'b0;
      n_cmp++; if (stall_n !== exp_busy) begin n_bad++; $display("FAIL stall_cycles: got %0d want %0d", stall_n, exp_busy); end
      n_cmp++; if (da !== exp_busy + 1) begin n_bad++; $display("FAIL stall_done_cycle: got %0d want %0d", da, exp_busy + 1); end
      n_cmp++; if (st_d !== 1'b0) begin n_bad++; $display("FAIL stall_at_done: got %b want %b", st_d, 1'b0); end
      n_cmp++; if (rd_d !== 32'd0) begin n_bad++; $display("FAIL mfhi_at_done: got %h want %h", rd_d, 32'd0); end
      @(negedge clk);
      rd_req = 1'b0;
      n_cmp++; if (lo !== 32'd6) begin n_bad++; $display("FAIL mtlo_refused_lo: got %h want %h", lo, 32'd6); end
   endtask

   task automatic test_move_to;
      op_valid = 1'b1; op_code = 3'b100; rs_content = 32'h1234_5678; rd_req = 1'b1; rd_sel = 1'b1;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mthi_accept_stall: got %b want %b", stall, 1'b0); end
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (rd_data !== 32'h1234_5678) begin n_bad++; $display("FAIL mfhi_after_mthi: got %h want %h", rd_data, 32'h1234_5678); end
      n_cmp++; if ({stall, done, op_ready} !== 3'b001) begin n_bad++;
         $display("FAIL mthi_flags: got %b want %b", {stall, done, op_ready}, 3'b001); end
      op_valid = 1'b1; op_code = 3'b101; rs_content = 32'hCAFE_F00D; rd_sel = 1'b0;
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (rd_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mflo_after_mtlo: got %h want %h", rd_data, 32'hCAFE_F00D); end
      op_valid = 1'b1; op_code = 3'b110; rs_content = 32'hFFFF_0000; rt_content = 32'd1;
      @(posedge clk); #1;
      op_valid = 1'b0; rd_req = 1'b0;
      @(negedge clk);
      n_cmp++; if ({hi, lo} !== {32'h1234_5678, 32'hCAFE_F00D}) begin n_bad++;
         $display("FAIL ignored_opcode: got %h want %h", {hi, lo}, {32'h1234_5678, 32'hCAFE_F00D}); end
      n_cmp++; if ({op_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL ignored_opcode_state: got %b want %b", {op_ready, busy}, 2'b10); end
   endtask

   task automatic test_reset_in_run;
      int done_n;
      logic busy10;
      busy10 = 1'b0;
      op_valid = 1'b1; op_code = 3'b000; rs_content = 32'd3; rt_content = 32'h4000_0000;
      @(posedge clk); #1;
      op_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 10) busy10 = busy;
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy10 !== 1'b1) begin n_bad++; $display("FAIL busy_before_reset: got %b want %b", busy10, 1'b1); end
      n_cmp++; if ({op_ready, busy, done} !== 3'b100) begin n_bad++;
         $display("FAIL run_reset_flags: got %b want %b", {op_ready, busy, done}, 3'b100); end
      n_cmp++; if ({hi, lo} !== 64'd0) begin n_bad++; $display("FAIL run_reset_hilo: got %h want %h", {hi, lo}, 64'd0); end
      reset = 1'b0;
      done_n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) done_n++;
      end
      n_cmp++; if (done_n !== 0) begin n_bad++; $display("FAIL run_reset_no_done: got %0d want %0d", done_n, 0); end
   endtask

   task automatic test_early_out;
      int bn, da; logic rdy;
      run_op(3'b001, 32'd3, 32'd5, bn, da, rdy);
      n_cmp++; if (lo !== 32'd15) begin n_bad++; $display("FAIL eo_3x5_lo: got %h want %h", lo, 32'd15); end
      n_cmp++; if (bn !== (EARLY ? 4 : 33)) begin n_bad++; $display("FAIL eo_3x5_busy: got %0d want %0d", bn, EARLY ? 4 : 33); end
      run_op(3'b001, 32'd3, 32'd0, bn, da, rdy);
      n_cmp++; if ({hi, lo} !== 64'd0) begin n_bad++; $display("FAIL eo_3x0_hilo: got %h want %h", {hi, lo}, 64'd0); end
      n_cmp++; if (bn !== (EARLY ? 2 : 33)) begin n_bad++; $display("FAIL eo_3x0_busy: got %0d want %0d", bn, EARLY ? 2 : 33); end
   endtask

   initial begin
      test_reset;
      test_multu_max;
      test_mult_signed;
      test_back_to_back_div;
      test_div_edges;
      test_stall_read;
      test_move_to;
      test_reset_in_run;
      test_early_out;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
